// File: rtl/reg_exec_seq_pkg.sv
// Shared definitions for the execute/write-back sequencer: op codes, FSM states, widths.
package reg_exec_seq_pkg;

  localparam int DW_DFLT  = 32;
  localparam int AW_DFLT  = 3;
  localparam int SHW_DFLT = 5;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SLL = 3'b110,
    OP_SRL = 3'b111
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_SHIFT = 3'd3,
    S_WB    = 3'd4
  } state_t;

  function automatic logic is_shift(input op_t o);
    return (o == OP_SLL) || (o == OP_SRL);
  endfunction

endpackage

// File: rtl/reg_exec_seq_alu.sv
// Single-cycle combinational ALU for the non-shift ops; shift ops are iterated by the sequencer.
module alu32_core
  import reg_exec_seq_pkg::*;
#(
  parameter int DW = DW_DFLT
) (
  input  op_t           op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLT:  y = DW'($signed(a) < $signed(b));
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/reg_exec_seq.sv
// Multi-cycle read/execute/write-back sequencer driving an 8x32 register file.
// Latency 3 cycles from accept to write-back, plus one cycle per shifted bit.
module reg_exec_seq
  import reg_exec_seq_pkg::*;
#(
  parameter int DW  = DW_DFLT,
  parameter int AW  = AW_DFLT,
  parameter int SHW = SHW_DFLT
) (
  input  logic          clk,
  input  logic          cr,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] Addr_A,
  output logic [AW-1:0] Addr_B,
  input  logic [DW-1:0] QA,
  input  logic [DW-1:0] QB,
  output logic          WE,
  output logic [AW-1:0] Addr_W,
  output logic [DW-1:0] Di,
  output logic [DW-1:0] result
);

  state_t          state, state_d;
  op_t             op_q;
  logic [AW-1:0]   rd_q, rs_q, rt_q, addr_w_q;
  logic [DW-1:0]   opa, opb, res, alu_y;
  logic [SHW-1:0]  cnt;

  alu32_core #(.DW(DW)) u_alu (
    .op (op_q),
    .a  (opa),
    .b  (opb),
    .y  (alu_y)
  );

  // Read addresses come straight from the latched fields, so they are stable for all of READ.
  assign Addr_A = rs_q;
  assign Addr_B = rt_q;

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) state <= S_IDLE;
    else     state <= state_d;
  end

  // WE/done decode from the async-reset state register, so reset kills a write immediately.
  always_comb begin
    state_d = state;
    busy    = (state != S_IDLE);
    WE      = 1'b0;
    done    = 1'b0;
    Addr_W  = addr_w_q;
    Di      = result;
    case (state)
      S_IDLE:  if (start) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC: begin
        if (is_shift(op_q) && (opb[SHW-1:0] != '0)) state_d = S_SHIFT;
        else                                          state_d = S_WB;
      end
      S_SHIFT: if (cnt == SHW'(1)) state_d = S_WB;
      S_WB: begin
        WE      = 1'b1;
        done    = 1'b1;
        Addr_W  = rd_q;
        Di      = res;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      op_q     <= OP_ADD;
      rd_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      addr_w_q <= '0;
      opa      <= '0;
      opb      <= '0;
      res      <= '0;
      cnt      <= '0;
      result   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op_t'(op);
            rd_q <= rd;
            rs_q <= rs;
            rt_q <= rt;
          end
        end
        S_READ: begin
          opa <= QA;
          opb <= QB;
        end
        S_EXEC: begin
          if (is_shift(op_q)) begin
            cnt <= opb[SHW-1:0];
            res <= opa;
          end else begin
            res <= alu_y;
          end
        end
        S_SHIFT: begin
          res <= (op_q == OP_SLL) ? (res << 1) : (res >> 1);
          cnt <= cnt - SHW'(1);
        end
        S_WB: begin
          result   <= res;
          addr_w_q <= rd_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_exec_seq.sv
// Bench for reg_exec_seq with a behavioural register file and an arithmetic reference model.
module tb_reg_exec_seq;

  logic        clk = 1'b0;
  logic        cr;
  logic        start;
  logic [2:0]  op, rd, rs, rt;
  logic        busy, done, WE;
  logic [2:0]  Addr_A, Addr_B, Addr_W;
  logic [31:0] QA, QB, Di, result;

  logic [31:0] rf [8];
  logic [31:0] mdl [8];
  logic        pl_en;
  logic [2:0]  pl_addr;
  logic [31:0] pl_dat;
  int          we_cnt = 0;
  int          vecs = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  reg_exec_seq dut (
    .clk    (clk),
    .cr     (cr),
    .start  (start),
    .op     (op),
    .rd     (rd),
    .rs     (rs),
    .rt     (rt),
    .busy   (busy),
    .done   (done),
    .Addr_A (Addr_A),
    .Addr_B (Addr_B),
    .QA     (QA),
    .QB     (QB),
    .WE     (WE),
    .Addr_W (Addr_W),
    .Di     (Di),
    .result (result)
  );

  assign QA = rf[Addr_A];
  assign QB = rf[Addr_B];

  always @(posedge clk) begin
    if (WE === 1'b1) begin
      rf[Addr_W] <= Di;
      we_cnt     <= we_cnt + 1;
    end else if (pl_en) begin
      rf[pl_addr] <= pl_dat;
    end
  end

  function automatic logic [31:0] model_op(input int o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int a, input logic [31:0] v);
    pl_en = 1'b1; pl_addr = 3'(a); pl_dat = v;
    @(posedge clk); @(negedge clk);
    pl_en = 1'b0;
    mdl[a] = v;
  endtask

  // Issues one instruction from an IDLE negedge; returns at the negedge after write-back.
  task automatic issue(input int o, input int d, input int s, input int t, input bit noise);
    logic [31:0] exp;
    int          exp_lat, lat, we0;
    exp     = model_op(o, mdl[s], mdl[t]);
    exp_lat = 3 + ((o >= 6) ? int'(mdl[t][4:0]) : 0);
    we0     = we_cnt;
    op = 3'(o); rd = 3'(d); rs = 3'(s); rt = 3'(t); start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (noise && k == 1) begin
        start = 1'b1; op = 3'(o ^ 1); rd = 3'(d + 1); rs = 3'(t); rt = 3'(s);
      end
      if (noise && k == 3) start = 1'b0;
      chk("busy_run", busy, 1);
      if (done === 1'b1) begin lat = k; break; end
      @(negedge clk);
    end
    chk("latency", lat, exp_lat);
    chk("we_wb", WE, 1);
    chk("addr_w_wb", Addr_W, d);
    chk("di_wb", Di, exp);
    @(negedge clk);
    mdl[d] = exp;
    chk("busy_idle", busy, 0);
    chk("we_idle", WE, 0);
    chk("done_idle", done, 0);
    chk("result", result, exp);
    chk("rf_write", rf[d], exp);
    chk("addr_w_hold", Addr_W, d);
    chk("di_hold", Di, exp);
    chk("we_pulses", we_cnt - we0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r6_before;
    int          we0;
    cr = 1'b0; start = 1'b0; op = '0; rd = '0; rs = '0; rt = '0;
    pl_en = 1'b0; pl_addr = '0; pl_dat = '0;
    for (int i = 0; i < 8; i++) begin rf[i] = '0; mdl[i] = '0; end
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", WE, 0);
    chk("rst_addr_a", Addr_A, 0);
    chk("rst_addr_b", Addr_B, 0);
    chk("rst_addr_w", Addr_W, 0);
    chk("rst_di", Di, 0);
    chk("rst_result", result, 0);
    cr = 1'b1;
    @(negedge clk);

    preload(1, 32'h5); preload(2, 32'h3);
    issue(0, 3, 1, 2, 0);
    chk("tp_add", rf[3], 32'h8);

    preload(1, 32'h1); preload(2, 32'h2);
    issue(1, 4, 1, 2, 0);
    chk("tp_sub", rf[4], 32'hFFFF_FFFF);
    issue(5, 5, 4, 1, 0);
    chk("tp_slt", rf[5], 32'h1);

    preload(1, 32'h8000_0001); preload(2, 32'h4);
    issue(6, 6, 1, 2, 0);
    chk("tp_sll", rf[6], 32'h10);
    preload(2, 32'h0);
    issue(7, 7, 1, 2, 0);
    chk("tp_srl0", rf[7], 32'h8000_0001);

    preload(1, 32'h5); preload(2, 32'h3);
    issue(0, 3, 1, 2, 1);
    chk("tp_ignore_other_rd", rf[4], mdl[4]);

    preload(1, 32'h7);
    issue(0, 1, 1, 1, 0);
    chk("tp_dep1", rf[1], 32'd14);
    issue(0, 1, 1, 1, 0);
    chk("tp_dep2", rf[1], 32'd28);

    // Abort a long shift with reset; the destination must keep its old contents.
    preload(1, 32'h8000_0001); preload(2, 32'd20); preload(6, 32'h1234_5678);
    r6_before = 32'h1234_5678;
    we0 = we_cnt;
    op = 3'd6; rd = 3'd6; rs = 3'd1; rt = 3'd2; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy_pre", busy, 1);
    cr = 1'b0;
    #1;
    chk("abort_we", WE, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    cr = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_idle", busy, 0);
    chk("abort_rf", rf[6], r6_before);
    chk("abort_no_we", we_cnt - we0, 0);
    chk("abort_result", result, 0);
    issue(0, 0, 1, 2, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0)
        preload(int'($urandom_range(0, 7)), $urandom);
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 8; i++) chk("final_rf", rf[i], mdl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
